// File: rtl/sram_fb_writer_pkg.sv
// Shared types and widths for the SRAM framebuffer write path.
package zxuno_sram_pkg;
    localparam int SRAM_AW = 19;
    localparam int SRAM_DW = 8;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} fb_wr_state_t;
endpackage

// File: rtl/sram_fb_writer_fifo.sv
// Show-ahead synchronous FIFO buffering stream bytes (address+data) ahead of the SRAM writer.
module fb_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 27
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // When full, a push is only legal alongside a pop; the slot being freed is the one written.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end
endmodule

// File: rtl/sram_fb_writer.sv
// Write side of the SRAM framebuffer: stream bytes or block fills become SRAM write cycles
// issued only in arbiter-granted slots.
//  state  | meaning
//  IDLE   | waiting for a pending source and a grant
//  SETUP  | address/data driven, we_n high; grant loss aborts and retries
//  STROBE | we_n low for WE_CYCLES cycles, cannot be aborted
//  HOLD   | we_n high, address/data held; pop FIFO or advance fill
module sram_fb_writer
    import zxuno_sram_pkg::*;
#(
    parameter int AW         = SRAM_AW,
    parameter int DW         = SRAM_DW,
    parameter int FIFO_DEPTH = 4,
    parameter int WE_CYCLES  = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          fill_start,
    input  logic [AW-1:0] fill_base,
    input  logic [AW-1:0] fill_len,
    input  logic [DW-1:0] fill_value,
    output logic          fill_busy,
    output logic          bus_req,
    input  logic          bus_grant,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_data_out,
    output logic          sram_data_oe,
    output logic          sram_we_n
);
    localparam int CW = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;

    fb_wr_state_t  state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          oe_q, oe_d;
    logic          we_n_q, we_n_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fill_busy_q, fill_busy_d;
    logic [AW-1:0] fill_addr_q, fill_addr_d;
    logic [AW-1:0] fill_rem_q, fill_rem_d;
    logic [DW-1:0] fill_val_q, fill_val_d;

    logic              fifo_full, fifo_empty, fifo_pop, fifo_push;
    logic [AW+DW-1:0]  fifo_head;

    assign wr_ready  = !fifo_full && !fill_busy_q;
    assign fifo_push = wr_valid && wr_ready;
    assign bus_req   = !fifo_empty || fill_busy_q || (state_q != IDLE);
    assign fill_busy = fill_busy_q;

    assign sram_addr     = addr_q;
    assign sram_data_out = data_q;
    assign sram_data_oe  = oe_q;
    assign sram_we_n     = we_n_q;

    fb_wr_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(AW+DW)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .din_i   ({wr_addr, wr_data}),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        oe_d        = oe_q;
        we_n_d      = we_n_q;
        cnt_d       = cnt_q;
        fill_busy_d = fill_busy_q;
        fill_addr_d = fill_addr_q;
        fill_rem_d  = fill_rem_q;
        fill_val_d  = fill_val_q;
        fifo_pop    = 1'b0;

        case (state_q)
            IDLE: begin
                if ((fill_busy_q || !fifo_empty) && bus_grant) begin
                    state_d = SETUP;
                    addr_d  = fill_busy_q ? fill_addr_q : fifo_head[AW+DW-1:DW];
                    data_d  = fill_busy_q ? fill_val_q  : fifo_head[DW-1:0];
                    oe_d    = 1'b1;
                    we_n_d  = 1'b1;
                end
                // A fill only starts from a fully quiet writer, so it never interleaves with stream bytes.
                if (fill_start && !fill_busy_q && fifo_empty && (fill_len != '0)) begin
                    fill_busy_d = 1'b1;
                    fill_addr_d = fill_base;
                    fill_rem_d  = fill_len;
                    fill_val_d  = fill_value;
                end
            end
            SETUP: begin
                if (!bus_grant) begin
                    state_d = IDLE;
                    oe_d    = 1'b0;
                    we_n_d  = 1'b1;
                end else begin
                    state_d = STROBE;
                    we_n_d  = 1'b0;
                    cnt_d   = CW'(WE_CYCLES - 1);
                end
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    we_n_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                state_d = IDLE;
                oe_d    = 1'b0;
                if (fill_busy_q) begin
                    fill_addr_d = fill_addr_q + 1'b1;
                    fill_rem_d  = fill_rem_q - 1'b1;
                    if (fill_rem_q == AW'(1)) fill_busy_d = 1'b0;
                end else begin
                    fifo_pop = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            oe_q        <= 1'b0;
            we_n_q      <= 1'b1;
            cnt_q       <= '0;
            fill_busy_q <= 1'b0;
            fill_addr_q <= '0;
            fill_rem_q  <= '0;
            fill_val_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            oe_q        <= oe_d;
            we_n_q      <= we_n_d;
            cnt_q       <= cnt_d;
            fill_busy_q <= fill_busy_d;
            fill_addr_q <= fill_addr_d;
            fill_rem_q  <= fill_rem_d;
            fill_val_q  <= fill_val_d;
        end
    end
endmodule

// File: tb/tb_sram_fb_writer.sv
// Bench for sram_fb_writer: directed scenarios plus a randomized stream checked against an
// in-order write log model.
module tb_sram_fb_writer;
    localparam int AW  = 19;
    localparam int DW  = 8;
    localparam int WEC = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          fill_start = 1'b0;
    logic [AW-1:0] fill_base = '0;
    logic [AW-1:0] fill_len = '0;
    logic [DW-1:0] fill_value = '0;
    logic          fill_busy;
    logic          bus_req;
    logic          bus_grant = 1'b1;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_data_out;
    logic          sram_data_oe;
    logic          sram_we_n;

    sram_fb_writer #(.AW(AW), .DW(DW), .FIFO_DEPTH(4), .WE_CYCLES(WEC)) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .fill_start(fill_start),
        .fill_base(fill_base), .fill_len(fill_len), .fill_value(fill_value),
        .fill_busy(fill_busy), .bus_req(bus_req), .bus_grant(bus_grant),
        .sram_addr(sram_addr), .sram_data_out(sram_data_out),
        .sram_data_oe(sram_data_oe), .sram_we_n(sram_we_n)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observed write log: one entry per we_n pulse.
    logic [AW-1:0] log_a[$];
    logic [DW-1:0] log_d[$];
    int            log_c[$];
    bit            log_fb[$];

    // Expected write sequence.
    logic [AW-1:0] exp_a[$];
    logic [DW-1:0] exp_d[$];

    task automatic clear_logs();
        log_a.delete(); log_d.delete(); log_c.delete(); log_fb.delete();
        exp_a.delete(); exp_d.delete();
    endtask

    bit            in_pulse = 0;
    int            low_n = 0;
    logic [AW-1:0] p_addr, prev_addr;
    logic [DW-1:0] p_data, prev_data;
    logic          prev_oe = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_pulse = 0;
            low_n    = 0;
        end else begin
            if (sram_we_n === 1'b0) begin
                if (!in_pulse) begin
                    in_pulse = 1;
                    low_n    = 0;
                    p_addr   = sram_addr;
                    p_data   = sram_data_out;
                    log_a.push_back(sram_addr);
                    log_d.push_back(sram_data_out);
                    log_c.push_back(cyc);
                    log_fb.push_back(fill_busy);
                    chk("setup_oe", int'(prev_oe), 1);
                    chk("setup_addr", int'(prev_addr), int'(sram_addr));
                    chk("setup_data", int'(prev_data), int'(sram_data_out));
                end
                low_n++;
                chk("strobe_oe", int'(sram_data_oe), 1);
                chk("strobe_addr", int'(sram_addr), int'(p_addr));
            end else if (in_pulse) begin
                in_pulse = 0;
                chk("we_width", low_n, WEC);
                chk("hold_oe", int'(sram_data_oe), 1);
                chk("hold_addr", int'(sram_addr), int'(p_addr));
                chk("hold_data", int'(sram_data_out), int'(p_data));
            end
            prev_oe   = sram_data_oe;
            prev_addr = sram_addr;
            prev_data = sram_data_out;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_log(input string tag, input int n, input int maxc);
        int k = 0;
        while (log_a.size() < n && k < maxc) begin
            @(negedge clk); k++;
        end
        chk({"wait_", tag}, int'(log_a.size() >= n), 1);
    endtask

    task automatic wait_idle(input string tag, input int maxc);
        int k = 0;
        @(negedge clk);
        while (bus_req && k < maxc) begin
            @(negedge clk); k++;
        end
        chk({"idle_", tag}, int'(bus_req), 0);
    endtask

    task automatic push1(input logic [AW-1:0] a, input logic [DW-1:0] d, output int n);
        wr_valid = 1; wr_addr = a; wr_data = d;
        chk("push_ready", int'(wr_ready), 1);
        @(posedge clk); #1;
        n = cyc;
        wr_valid = 0;
    endtask

    task automatic cmp_logs(input string tag);
        chk({tag, "_count"}, log_a.size(), exp_a.size());
        for (int i = 0; i < exp_a.size() && i < log_a.size(); i++) begin
            chk({tag, "_addr"}, int'(log_a[i]), int'(exp_a[i]));
            chk({tag, "_data"}, int'(log_d[i]), int'(exp_d[i]));
        end
    endtask

    initial begin
        int n0, k;
        logic [AW-1:0] a;
        logic [DW-1:0] d;

        // 1. reset with grant held high
        bus_grant = 1;
        #2 rst_n = 0;
        repeat (3) @(negedge clk);
        chk("rst_we_n", int'(sram_we_n), 1);
        chk("rst_oe", int'(sram_data_oe), 0);
        chk("rst_ready", int'(wr_ready), 1);
        chk("rst_bus_req", int'(bus_req), 0);
        chk("rst_addr", int'(sram_addr), 0);
        chk("rst_fill_busy", int'(fill_busy), 0);
        #2 rst_n = 1;
        repeat (2) @(negedge clk);
        chk("post_rst_we_n", int'(sram_we_n), 1);
        chk("post_rst_oe", int'(sram_data_oe), 0);
        chk("post_rst_ready", int'(wr_ready), 1);
        chk("post_rst_bus_req", int'(bus_req), 0);
        step();

        // 2. single write and its latency
        clear_logs();
        push1(19'h12345, 8'hA5, n0);
        exp_a.push_back(19'h12345); exp_d.push_back(8'hA5);
        wait_log("single", 1, 20);
        wait_idle("single", 20);
        cmp_logs("single");
        if (log_c.size() > 0) chk("single_latency", log_c[0] - n0, 2);
        step();

        // 3. five back-to-back bytes, FIFO fills after four
        clear_logs();
        n0 = 0;
        for (int i = 0; i < 5; i++) begin
            a = AW'($urandom); d = DW'($urandom);
            wr_valid = 1; wr_addr = a; wr_data = d;
            k = 0;
            @(negedge clk);
            while (!wr_ready && k < 50) begin @(negedge clk); k++; end
            chk("b2b_accept", int'(wr_ready), 1);
            exp_a.push_back(a); exp_d.push_back(d);
            step();
            if (i == 0) n0 = cyc;
            if (i == 3) begin
                @(negedge clk);
                chk("b2b_full_ready", int'(wr_ready), 0);
            end
        end
        wr_valid = 0;
        wait_log("b2b", 5, 60);
        wait_idle("b2b", 20);
        cmp_logs("b2b");
        if (log_c.size() == 5) begin
            chk("b2b_latency", log_c[0] - n0, 2);
            for (int i = 1; i < 5; i++) chk("b2b_spacing", log_c[i] - log_c[i-1], 3 + WEC);
        end
        step();

        // 4a. grant withdrawn during SETUP: aborted, then retried once
        clear_logs();
        push1(19'h00ABC, 8'h5A, n0);
        step();
        bus_grant = 0;
        repeat (4) @(negedge clk);
        chk("abort_no_write", log_a.size(), 0);
        chk("abort_we_n", int'(sram_we_n), 1);
        chk("abort_oe", int'(sram_data_oe), 0);
        chk("abort_bus_req", int'(bus_req), 1);
        step();
        bus_grant = 1;
        exp_a.push_back(19'h00ABC); exp_d.push_back(8'h5A);
        wait_log("retry", 1, 20);
        wait_idle("retry", 20);
        cmp_logs("retry");

        // 4b. grant withdrawn during STROBE: write still completes
        step();
        clear_logs();
        push1(19'h4F00D, 8'hC3, n0);
        step();
        step();
        chk("strobe_entered", int'(sram_we_n), 0);
        bus_grant = 0;
        exp_a.push_back(19'h4F00D); exp_d.push_back(8'hC3);
        repeat (WEC + 3) @(negedge clk);
        chk("strobe_done_bus_req", int'(bus_req), 0);
        cmp_logs("no_abort");
        step();
        bus_grant = 1;

        // 5a. zero-length fill ignored
        fill_base = 19'h00100; fill_len = '0; fill_value = 8'hEE; fill_start = 1;
        step();
        fill_start = 0;
        chk("fill0_busy", int'(fill_busy), 0);
        chk("fill0_bus_req", int'(bus_req), 0);

        // 5b. wrapping fill, with a stream byte held off until it finishes
        clear_logs();
        fill_base = 19'h7FFFE; fill_len = 19'd4; fill_value = 8'h3C; fill_start = 1;
        step();
        fill_start = 0;
        chk("fill_busy_start", int'(fill_busy), 1);
        chk("fill_ready_start", int'(wr_ready), 0);
        for (int i = 0; i < 4; i++) begin
            exp_a.push_back(AW'(32'h7FFFE + i)); exp_d.push_back(8'h3C);
        end
        exp_a.push_back(19'h00AAA); exp_d.push_back(8'h55);
        wr_valid = 1; wr_addr = 19'h00AAA; wr_data = 8'h55;
        k = 0;
        @(negedge clk);
        while (fill_busy && k < 100) begin
            chk("fill_ready_low", int'(wr_ready), 0);
            @(negedge clk); k++;
        end
        chk("fill_finished", int'(fill_busy), 0);
        chk("fill_writes_at_end", log_a.size(), 4);
        chk("fill_end_ready", int'(wr_ready), 1);
        step();
        wr_valid = 0;
        wait_log("fill", 5, 30);
        wait_idle("fill", 20);
        cmp_logs("fill");
        for (int i = 0; i < 4 && i < log_fb.size(); i++) chk("fill_busy_cover", int'(log_fb[i]), 1);
        step();

        // 6. async reset in the middle of the strobe
        clear_logs();
        push1(19'h01234, 8'h77, n0);
        k = 0;
        @(negedge clk);
        while (sram_we_n !== 1'b0 && k < 20) begin @(negedge clk); k++; end
        chk("rst_mid_strobe_low", int'(sram_we_n), 0);
        #2 rst_n = 0;
        #1;
        chk("rst_mid_we_n", int'(sram_we_n), 1);
        chk("rst_mid_oe", int'(sram_data_oe), 0);
        @(negedge clk);
        #2 rst_n = 1;
        repeat (6) @(negedge clk);
        chk("rst_mid_ready", int'(wr_ready), 1);
        chk("rst_mid_bus_req", int'(bus_req), 0);
        chk("rst_mid_no_retry", log_a.size(), 1);
        step();

        // 7. randomized stream with random grants
        clear_logs();
        for (int c = 0; c < 400; c++) begin
            bus_grant = ($urandom_range(0, 3) != 0);
            wr_valid  = ($urandom_range(0, 1) == 1);
            wr_addr   = AW'($urandom);
            wr_data   = DW'($urandom);
            @(negedge clk);
            if (wr_valid && wr_ready) begin
                exp_a.push_back(wr_addr); exp_d.push_back(wr_data);
            end
            step();
        end
        wr_valid = 0; bus_grant = 1;
        wait_idle("rand", 200);
        cmp_logs("rand");

        // 8. random fill length/base, address wraps modulo 2^AW
        step();
        clear_logs();
        fill_base = AW'(32'h7FFFF - $urandom_range(0, 3));
        fill_len = AW'($urandom_range(1, 7));
        fill_value = DW'($urandom);
        for (int i = 0; i < int'(fill_len); i++) begin
            exp_a.push_back(AW'((int'(fill_base) + i) % (1 << AW)));
            exp_d.push_back(fill_value);
        end
        fill_start = 1;
        step();
        fill_start = 0;
        wait_idle("rfill", 100);
        cmp_logs("rfill");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
